// File: rtl/bmf_h_decoder_pkg.sv
// Shared defaults and types for the Boolean matrix-factorisation H decoder.
// A basis row holds M output bits; the matrix holds one row per latent factor.
package bmf_h_decoder_pkg;
  localparam int K_DEF = 3;
  localparam int M_DEF = 4;

  typedef logic [M_DEF-1:0] row_t;
  typedef row_t [K_DEF-1:0] matrix_t;
endpackage

// File: rtl/bmf_matrix_regs.sv
// Shadow/active basis matrices with a sticky flag for out-of-range row writes.
// The commit copies the shadow as it stood before any write landing on the same edge.
module bmf_matrix_regs
  import bmf_h_decoder_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int M  = M_DEF,
  parameter int CW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_row,
  input  logic [M-1:0]          cfg_data,
  input  logic                  cfg_commit,
  output logic [K-1:0][M-1:0]   h_active,
  output logic                  cfg_err
);
  logic [K-1:0][M-1:0] shadow_q, shadow_d;
  logic [K-1:0][M-1:0] active_q, active_d;
  logic                err_q, err_d;
  logic                row_ok;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    row_ok   = 1'b0;
    if (cfg_commit) active_d = shadow_q;
    for (int r = 0; r < K; r++) begin
      if (cfg_row == CW'(r)) begin
        row_ok = 1'b1;
        if (cfg_we) shadow_d[r] = cfg_data;
      end
    end
    if (cfg_we && !row_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign h_active = active_q;
  assign cfg_err  = err_q;
endmodule

// File: rtl/bmf_h_decoder.sv
// Two-stage Boolean matrix-product decoder: S1 captures the K x M AND terms,
// S2 captures the per-output OR reduction. Ready/valid with bubble collapse.
module bmf_h_decoder
  import bmf_h_decoder_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int M = M_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0] cfg_row,
  input  logic [M-1:0]                       cfg_data,
  input  logic                               cfg_commit,
  output logic                               cfg_err,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [K-1:0]                       in_k,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [M-1:0]                       out_y,
  output logic [15:0]                        out_count
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [K-1:0][M-1:0] h_active, and_terms;
  logic [K-1:0][M-1:0] s1_and_q, s1_and_d;
  logic [2:1]          vld_pipe_q, vld_pipe_d;
  logic [M-1:0]        out_y_q, out_y_d, or_red;
  logic [15:0]         out_count_q, out_count_d;
  logic                s1_adv, s2_adv;

  bmf_matrix_regs #(.K(K), .M(M), .CW(CW)) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_row    (cfg_row),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .h_active   (h_active),
    .cfg_err    (cfg_err)
  );

  // Terms use the active matrix as it stands at the accepting edge.
  for (genvar j = 0; j < K; j++) begin : g_and
    assign and_terms[j] = {M{in_k[j]}} & h_active[j];
  end

  assign s2_adv = !vld_pipe_q[2] || out_ready;
  assign s1_adv = !vld_pipe_q[1] || s2_adv;

  always_comb begin
    or_red = '0;
    for (int j = 0; j < K; j++) or_red = or_red | s1_and_q[j];
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    s1_and_d    = s1_and_q;
    out_y_d     = out_y_q;
    out_count_d = out_count_q;
    if (s1_adv) begin
      vld_pipe_d[1] = in_valid;
      if (in_valid) s1_and_d = and_terms;
    end
    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) out_y_d = or_red;
    end
    if (vld_pipe_q[2] && out_ready) out_count_d = out_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      s1_and_q    <= '0;
      out_y_q     <= '0;
      out_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_and_q    <= s1_and_d;
      out_y_q     <= out_y_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe_q[2];
  assign out_y     = out_y_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_bmf_h_decoder.sv
// Scoreboard bench for bmf_h_decoder: expected words are queued at acceptance
// from a reference matrix model and checked as outputs transfer.
module tb_bmf_h_decoder;
  localparam int K = 3;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_row = '0;
  logic [M-1:0] cfg_data = '0;
  logic         cfg_commit = 1'b0;
  logic         cfg_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [K-1:0] in_k = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [M-1:0] out_y;
  logic [15:0]  out_count;

  int vectors = 0;
  int miscompares = 0;
  logic [M-1:0] exp_q[$];
  logic [M-1:0] h_sh[K];
  logic [M-1:0] h_act[K];

  bmf_h_decoder #(.K(K), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] model(input logic [K-1:0] k);
    logic [M-1:0] r = '0;
    for (int j = 0; j < K; j++) if (k[j]) r |= h_act[j];
    return r;
  endfunction

  // Output side of the scoreboard: one check per completed transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [M-1:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_out got=%h expected=none", out_y);
      end else begin
        e = exp_q.pop_front();
        if (out_y !== e) begin
          miscompares++;
          $display("FAIL out_y got=%h expected=%h", out_y, e);
        end
      end
    end
  end

  task automatic model_clear();
    for (int r = 0; r < K; r++) begin h_sh[r] = '0; h_act[r] = '0; end
  endtask

  task automatic cfg_write(input int row, input logic [M-1:0] d);
    cfg_we = 1'b1; cfg_row = 2'(row); cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (row < K) h_sh[row] = d;
  endtask

  task automatic cfg_commit_now();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    h_act = h_sh;
  endtask

  task automatic send_vec(input logic [K-1:0] k);
    int n = 0;
    in_valid = 1'b1; in_k = k;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout in_ready got=0 expected=1");
    end else exp_q.push_back(model(k));
    @(posedge clk); #1;
    in_valid = 1'b0; in_k = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending got=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_clear(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vectors += 5;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
    if (out_y !== '0) begin miscompares++; $display("FAIL rst_out_y got=%h expected=0", out_y); end
    if (out_count !== 16'd0) begin miscompares++; $display("FAIL rst_out_count got=%0d expected=0", out_count); end
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_err got=%b expected=0", cfg_err); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
  endtask

  task automatic test_unconfigured();
    send_vec(3'b111);
    send_vec(3'b101);
    drain();
  endtask

  // Input presented in cycle c is visible on out_valid in cycle c+2.
  task automatic test_basic();
    cfg_write(0, 4'b0001); cfg_write(1, 4'b0010); cfg_write(2, 4'b0100);
    cfg_commit_now();
    send_vec(3'b101);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early got=%b expected=0", out_valid); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 4'b0101) begin
      miscompares++; $display("FAIL latency_basic got=%b/%h expected=1/5", out_valid, out_y);
    end
    drain();
  endtask

  task automatic test_or_overlap();
    cfg_write(0, 4'b0011); cfg_write(1, 4'b0110); cfg_write(2, 4'b0000);
    cfg_commit_now();
    send_vec(3'b011);
    send_vec(3'b000);
    drain();
  endtask

  task automatic test_back_to_back();
    cfg_write(0, 4'b1001); cfg_write(1, 4'b0100); cfg_write(2, 4'b0010);
    cfg_commit_now();
    for (int i = 0; i < 16; i++) send_vec(3'($urandom_range(0, 7)));
    drain();
  endtask

  task automatic test_backpressure();
    logic [K-1:0] vecs[4];
    int acc = 0;
    int n = 0;
    vecs = '{3'b001, 3'b010, 3'b100, 3'b111};
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_k = vecs[acc];
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(model(vecs[acc])); acc++; end
      @(posedge clk); #1;
    end
    vectors += 2;
    if (acc != 2) begin miscompares++; $display("FAIL bp_accepts got=%0d expected=2", acc); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got=%b expected=0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      in_k = 3'($urandom_range(0, 7));
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_y !== exp_q[0]) begin
        miscompares++; $display("FAIL bp_hold got=%b/%h expected=1/%h", out_valid, out_y, exp_q[0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (acc < 4 && n < 50) begin
      in_valid = 1'b1; in_k = vecs[acc];
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(model(vecs[acc])); acc++; end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (acc != 4) begin miscompares++; $display("FAIL bp_release_accepts got=%0d expected=4", acc); end
    drain();
  endtask

  // Commit and acceptance on the same edge: that vector sees the old matrix.
  task automatic test_commit_timing();
    cfg_write(0, 4'b0001); cfg_write(1, 4'b0000); cfg_write(2, 4'b0000);
    cfg_commit_now();
    cfg_write(0, 4'b1111);
    cfg_commit = 1'b1; in_valid = 1'b1; in_k = 3'b001;
    @(negedge clk);
    if (in_ready) exp_q.push_back(model(3'b001));
    else begin vectors++; miscompares++; $display("FAIL ct_in_ready got=0 expected=1"); end
    @(posedge clk); #1;
    cfg_commit = 1'b0; in_valid = 1'b0;
    h_act = h_sh;
    send_vec(3'b001);
    drain();
  endtask

  // Write and commit on the same edge: active takes the pre-write shadow.
  task automatic test_we_commit_coincide();
    cfg_write(2, 4'b0100);
    cfg_commit_now();
    cfg_write(2, 4'b0010);
    cfg_we = 1'b1; cfg_row = 2'd2; cfg_data = 4'b1000; cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    h_act = h_sh; h_sh[2] = 4'b1000;
    send_vec(3'b100);
    drain();
    cfg_commit_now();
    send_vec(3'b100);
    drain();
  endtask

  task automatic test_cfg_error();
    vectors++;
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL err_pre got=%b expected=0", cfg_err); end
    cfg_write(3, 4'b1111);
    vectors++;
    if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL err_set got=%b expected=1", cfg_err); end
    cfg_commit_now();
    send_vec(3'b111);
    send_vec(3'b010);
    drain();
    cfg_write(1, 4'b0101);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b expected=1", cfg_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_vec(3'b001);
    send_vec(3'b011);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rm_pre_valid got=%b expected=1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_out_valid got=%b expected=0", out_valid); end
    if (out_count !== 16'd0) begin miscompares++; $display("FAIL rm_out_count got=%0d expected=0", out_count); end
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL rm_cfg_err got=%b expected=0", cfg_err); end
    exp_q.delete(); model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_ghost got=%b expected=0", out_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_count_wrap();
    cfg_write(0, 4'b0011); cfg_write(1, 4'b1100); cfg_write(2, 4'b0110);
    cfg_commit_now();
    for (int i = 0; i < 65535; i++) send_vec(3'($urandom_range(0, 7)));
    drain();
    vectors++;
    if (out_count !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_ffff got=%h expected=ffff", out_count); end
    send_vec(3'b110);
    drain();
    vectors++;
    if (out_count !== 16'h0000) begin miscompares++; $display("FAIL cnt_wrap got=%h expected=0000", out_count); end
  endtask

  initial begin
    test_reset();
    test_unconfigured();
    test_basic();
    test_or_overlap();
    test_back_to_back();
    test_backpressure();
    test_commit_timing();
    test_we_commit_coincide();
    test_cfg_error();
    test_reset_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
